// File: rtl/ahbl_to_apb.sv
// ahbl_to_apb
// -----------------------------------------------------------------------------
// AHB-lite slave to APB4 master bridge. It carries one single transfer at a
// time (no bursts, no pipelining on the APB side). Exclusive accesses always
// report failure through hexokay = 0, but the underlying transfer is still
// performed on APB.
//
// Data-phase timing with a zero-wait APB slave:
//   SAMPLE -> SETUP -> ACCESS -> RESP
//   hready_resp is low for 3 cycles and high on the 4th. Each APB wait state
//   extends ACCESS by one cycle.
//
// Optional feature (macro AHBL_TO_APB_TIMEOUT_EN):
//   ACCESS is abandoned after TIMEOUT_CYCLES cycles without pready. The bridge
//   then returns the two-cycle AHB error response. Without the macro, ACCESS
//   waits for pready indefinitely.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ahbls_hready        bus-level HREADY (address phase qualifier)
//   ahbls_hready_resp   data-phase ready from this slave
//   ahbls_hresp         error response
//   ahbls_haddr/hwrite/htrans/hsize/hprot/hexcl  AHB address-phase controls
//   ahbls_hwdata        write data (data phase)
//   ahbls_hrdata        read data
//   ahbls_hexokay       exclusive okay, tied low
//   apbm_*              APB4 master interface
// -----------------------------------------------------------------------------
module ahbl_to_apb #(
  parameter int W_ADDR         = 32,
  parameter int W_DATA         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [3:0]        ahbls_hprot,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic              ahbls_hexcl,
  output logic              ahbls_hexokay,

  output logic [W_ADDR-1:0] apbm_paddr,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [W_DATA-1:0] apbm_pwdata,
  output logic [3:0]        apbm_pstrb,
  output logic [2:0]        apbm_pprot,
  input  logic [W_DATA-1:0] apbm_prdata,
  input  logic              apbm_pready,
  input  logic              apbm_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_nxt;

  logic       accept;
  logic       timeout;
  logic [3:0] strb_calc;

  // A new address phase may only be taken while this slave is ready; in all
  // other states the request lines are not looked at.
  assign accept = ahbls_hready && ahbls_htrans[1] && ahbls_hready_resp;

  // Exclusive accesses are never granted.
  assign ahbls_hexokay = 1'b0;

  // ---------------------------------------------------------------------------
  // Optional ACCESS timeout
  // ---------------------------------------------------------------------------
`ifdef AHBL_TO_APB_TIMEOUT_EN
  localparam int W_TO = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W_TO-1:0] TO_LAST = W_TO'(TIMEOUT_CYCLES - 1);

  logic [W_TO-1:0] to_cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == S_ACCESS && !apbm_pready) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Fires on the last permitted ACCESS cycle if pready is still low; a pready
  // in that same cycle still completes the transfer normally.
  assign timeout = (state == S_ACCESS) && !apbm_pready && (to_cnt == TO_LAST);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // psel/penable/hready_resp/hresp are decoded from the state register alone,
  // so an asynchronous reset drops them immediately.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt         = state;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    apbm_psel         = 1'b0;
    apbm_penable      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        ahbls_hready_resp = 1'b0;
        state_nxt         = S_SETUP;
      end
      S_SETUP: begin
        ahbls_hready_resp = 1'b0;
        apbm_psel         = 1'b1;
        state_nxt         = S_ACCESS;
      end
      S_ACCESS: begin
        ahbls_hready_resp = 1'b0;
        apbm_psel         = 1'b1;
        apbm_penable      = 1'b1;
        if (apbm_pready) begin
          state_nxt = apbm_pslverr ? S_ERR1 : S_RESP;
        end else if (timeout) begin
          state_nxt = S_ERR1;
        end
      end
      S_RESP: begin
        state_nxt = accept ? S_SAMPLE : S_IDLE;
      end
      S_ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
        state_nxt         = S_ERR2;
      end
      S_ERR2: begin
        ahbls_hresp = 1'b1;
        state_nxt   = accept ? S_SAMPLE : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write strobes from the address-phase size and low address bits
  // ---------------------------------------------------------------------------
  always_comb begin
    strb_calc = 4'b1111;
    case (ahbls_hsize)
      3'd0:    strb_calc = 4'b0001 << ahbls_haddr[1:0];
      3'd1:    strb_calc = 4'b0011 << {ahbls_haddr[1], 1'b0};
      default: strb_calc = 4'b1111;
    endcase
    // APB4 requires all strobes low on reads.
    if (!ahbls_hwrite) strb_calc = 4'b0000;
  end

  // ---------------------------------------------------------------------------
  // Address/data path registers
  // ---------------------------------------------------------------------------
  // Address-phase attributes are captured straight into the APB output
  // registers; they can only change on an accept, which never happens between
  // SETUP and the final ACCESS cycle, so the APB side stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apbm_paddr   <= '0;
      apbm_pwrite  <= 1'b0;
      apbm_pstrb   <= 4'b0000;
      apbm_pprot   <= 3'b000;
      apbm_pwdata  <= '0;
      ahbls_hrdata <= '0;
    end else begin
      if (accept) begin
        apbm_paddr  <= ahbls_haddr;
        apbm_pwrite <= ahbls_hwrite;
        apbm_pstrb  <= strb_calc;
        // {data/instr, secure, privileged}
        apbm_pprot  <= {~ahbls_hprot[0], 1'b0, ahbls_hprot[1]};
      end
      if (state == S_SAMPLE) begin
        apbm_pwdata <= ahbls_hwdata;
      end
      if (state == S_ACCESS && apbm_pready && !apbm_pslverr) begin
        ahbls_hrdata <= apbm_prdata;
      end
    end
  end

  // Inputs that carry no information for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{ahbls_htrans[0], ahbls_hprot[3:2], ahbls_hexcl};

endmodule

// File: tb/tb_ahbl_to_apb.sv
// tb_ahbl_to_apb
// -----------------------------------------------------------------------------
// Directed bench for ahbl_to_apb. The bridge is the only slave, so the bus
// HREADY is its own hready_resp. Inputs are driven 1 ns after the rising edge,
// outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_ahbl_to_apb;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ahbls_hready;
  logic              ahbls_hready_resp;
  logic              ahbls_hresp;
  logic [W_ADDR-1:0] ahbls_haddr;
  logic              ahbls_hwrite;
  logic [1:0]        ahbls_htrans;
  logic [2:0]        ahbls_hsize;
  logic [3:0]        ahbls_hprot;
  logic [W_DATA-1:0] ahbls_hwdata;
  logic [W_DATA-1:0] ahbls_hrdata;
  logic              ahbls_hexcl;
  logic              ahbls_hexokay;
  logic [W_ADDR-1:0] apbm_paddr;
  logic              apbm_psel;
  logic              apbm_penable;
  logic              apbm_pwrite;
  logic [W_DATA-1:0] apbm_pwdata;
  logic [3:0]        apbm_pstrb;
  logic [2:0]        apbm_pprot;
  logic [W_DATA-1:0] apbm_prdata;
  logic              apbm_pready;
  logic              apbm_pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ahbls_hready = ahbls_hready_resp;

  ahbl_to_apb #(
    .W_ADDR         (W_ADDR),
    .W_DATA         (W_DATA),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ahbls_hready      (ahbls_hready),
    .ahbls_hready_resp (ahbls_hready_resp),
    .ahbls_hresp       (ahbls_hresp),
    .ahbls_haddr       (ahbls_haddr),
    .ahbls_hwrite      (ahbls_hwrite),
    .ahbls_htrans      (ahbls_htrans),
    .ahbls_hsize       (ahbls_hsize),
    .ahbls_hprot       (ahbls_hprot),
    .ahbls_hwdata      (ahbls_hwdata),
    .ahbls_hrdata      (ahbls_hrdata),
    .ahbls_hexcl       (ahbls_hexcl),
    .ahbls_hexokay     (ahbls_hexokay),
    .apbm_paddr        (apbm_paddr),
    .apbm_psel         (apbm_psel),
    .apbm_penable      (apbm_penable),
    .apbm_pwrite       (apbm_pwrite),
    .apbm_pwdata       (apbm_pwdata),
    .apbm_pstrb        (apbm_pstrb),
    .apbm_pprot        (apbm_pprot),
    .apbm_prdata       (apbm_prdata),
    .apbm_pready       (apbm_pready),
    .apbm_pslverr      (apbm_pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // hready_resp, hresp, psel, penable in one go.
  task automatic chk_ctl(input string tag, input logic hr, input logic hs,
                         input logic ps, input logic pe);
    check({tag, " hready_resp"}, 32'(ahbls_hready_resp), 32'(hr));
    check({tag, " hresp"},       32'(ahbls_hresp),       32'(hs));
    check({tag, " psel"},        32'(apbm_psel),         32'(ps));
    check({tag, " penable"},     32'(apbm_penable),      32'(pe));
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [3:0] prot, input logic excl);
    ahbls_htrans = 2'b10;
    ahbls_haddr  = a;
    ahbls_hwrite = wr;
    ahbls_hsize  = sz;
    ahbls_hprot  = prot;
    ahbls_hexcl  = excl;
  endtask

  task automatic bus_idle();
    ahbls_htrans = 2'b00;
    ahbls_hexcl  = 1'b0;
  endtask

  // Guards against a hung simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    ahbls_haddr  = '0;
    ahbls_hwrite = 1'b0;
    ahbls_htrans = 2'b00;
    ahbls_hsize  = 3'd0;
    ahbls_hprot  = 4'd0;
    ahbls_hwdata = '0;
    ahbls_hexcl  = 1'b0;
    apbm_prdata  = '0;
    apbm_pready  = 1'b0;
    apbm_pslverr = 1'b0;

    // ---------------- Reset state ----------------
    repeat (2) @(posedge clk);
    neg();
    chk_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset hrdata",  ahbls_hrdata,           32'h0);
    check("reset paddr",   apbm_paddr,             32'h0);
    check("reset pwdata",  apbm_pwdata,            32'h0);
    check("reset pwrite",  32'(apbm_pwrite),       32'h0);
    check("reset pstrb",   32'(apbm_pstrb),        32'h0);
    check("reset pprot",   32'(apbm_pprot),        32'h0);
    check("reset hexokay", 32'(ahbls_hexokay),     32'h0);
    rst_n = 1'b1;
    nxt();

    // ---------------- Read, zero wait ----------------
    addr_phase(32'h4000_0004, 1'b0, 3'd2, 4'b0011, 1'b0);
    apbm_pready = 1'b1;
    apbm_prdata = 32'hDEAD_BEEF;
    neg(); chk_ctl("rd0 idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
    bus_idle();
    neg(); chk_ctl("rd0 sample", 1'b0, 1'b0, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("rd0 setup", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rd0 paddr",  apbm_paddr,        32'h4000_0004);
    check("rd0 pwrite", 32'(apbm_pwrite),  32'h0);
    check("rd0 pstrb",  32'(apbm_pstrb),   32'h0);
    check("rd0 pprot",  32'(apbm_pprot),   32'h1);
    nxt();
    neg(); chk_ctl("rd0 access", 1'b0, 1'b0, 1'b1, 1'b1); nxt();
    neg(); chk_ctl("rd0 resp", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rd0 hrdata", ahbls_hrdata, 32'hDEAD_BEEF);
    nxt();

    // ---------------- Byte write with 2 wait states ----------------
    addr_phase(32'h4000_0013, 1'b1, 3'd0, 4'b0010, 1'b0);
    apbm_pready = 1'b0;
    neg(); chk_ctl("wrb idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
    bus_idle();
    ahbls_hwdata = 32'h5A00_0000;
    neg(); chk_ctl("wrb sample", 1'b0, 1'b0, 1'b0, 1'b0); nxt();
    ahbls_hwdata = 32'h1111_1111;
    neg(); chk_ctl("wrb setup", 1'b0, 1'b0, 1'b1, 1'b0);
    check("wrb setup pstrb",  32'(apbm_pstrb),  32'h8);
    check("wrb setup pwdata", apbm_pwdata,      32'h5A00_0000);
    check("wrb setup pwrite", 32'(apbm_pwrite), 32'h1);
    check("wrb setup paddr",  apbm_paddr,       32'h4000_0013);
    check("wrb setup pprot",  32'(apbm_pprot),  32'h5);
    nxt();
    for (int i = 0; i < 3; i++) begin
      apbm_pready = (i == 2);
      neg(); chk_ctl("wrb access", 1'b0, 1'b0, 1'b1, 1'b1);
      check("wrb access pstrb",  32'(apbm_pstrb),  32'h8);
      check("wrb access pwdata", apbm_pwdata,      32'h5A00_0000);
      check("wrb access pwrite", 32'(apbm_pwrite), 32'h1);
      check("wrb access paddr",  apbm_paddr,       32'h4000_0013);
      nxt();
    end
    neg(); chk_ctl("wrb resp", 1'b1, 1'b0, 1'b0, 1'b0); nxt();

    // ---------------- Slave error ----------------
    addr_phase(32'h4000_0008, 1'b0, 3'd2, 4'b0001, 1'b0);
    apbm_pready  = 1'b1;
    apbm_pslverr = 1'b1;
    apbm_prdata  = 32'h1234_5678;
    neg(); chk_ctl("err idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
    bus_idle();
    neg(); chk_ctl("err sample", 1'b0, 1'b0, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("err setup", 1'b0, 1'b0, 1'b1, 1'b0); nxt();
    neg(); chk_ctl("err access", 1'b0, 1'b0, 1'b1, 1'b1); nxt();
    apbm_pslverr = 1'b0;
    neg(); chk_ctl("err err1", 1'b0, 1'b1, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("err err2", 1'b1, 1'b1, 1'b0, 1'b0);
    check("err hrdata kept", ahbls_hrdata, 32'hDEAD_BEEF);
    nxt();
    neg(); chk_ctl("err back to idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();

    // ---------------- Back-to-back read then exclusive write ----------------
    addr_phase(32'h4000_0000, 1'b0, 3'd2, 4'b0001, 1'b0);
    apbm_pready = 1'b1;
    apbm_prdata = 32'hCAFE_F00D;
    neg(); chk_ctl("b2b rd idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
    bus_idle();
    neg(); chk_ctl("b2b rd sample", 1'b0, 1'b0, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("b2b rd setup", 1'b0, 1'b0, 1'b1, 1'b0); nxt();
    neg(); chk_ctl("b2b rd access", 1'b0, 1'b0, 1'b1, 1'b1); nxt();
    addr_phase(32'h4000_0020, 1'b1, 3'd2, 4'b0001, 1'b1);
    neg(); chk_ctl("b2b rd resp", 1'b1, 1'b0, 1'b0, 1'b0);
    check("b2b rd hrdata", ahbls_hrdata, 32'hCAFE_F00D);
    check("b2b hexokay resp", 32'(ahbls_hexokay), 32'h0);
    nxt();
    bus_idle();
    ahbls_hwdata = 32'hA5A5_A5A5;
    neg(); chk_ctl("b2b wr sample", 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b hexokay sample", 32'(ahbls_hexokay), 32'h0);
    nxt();
    neg(); chk_ctl("b2b wr setup", 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b wr paddr",  apbm_paddr,       32'h4000_0020);
    check("b2b wr pwrite", 32'(apbm_pwrite), 32'h1);
    check("b2b wr pwdata", apbm_pwdata,      32'hA5A5_A5A5);
    check("b2b wr pstrb",  32'(apbm_pstrb),  32'hF);
    nxt();
    neg(); chk_ctl("b2b wr access", 1'b0, 1'b0, 1'b1, 1'b1); nxt();
    neg(); chk_ctl("b2b wr resp", 1'b1, 1'b0, 1'b0, 1'b0);
    check("b2b hexokay wr resp", 32'(ahbls_hexokay), 32'h0);
    nxt();

    // ---------------- Reset during ACCESS ----------------
    addr_phase(32'h4000_0032, 1'b1, 3'd1, 4'b0001, 1'b0);
    apbm_pready = 1'b0;
    neg(); chk_ctl("rst idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
    bus_idle();
    ahbls_hwdata = 32'hBEEF_0000;
    neg(); chk_ctl("rst sample", 1'b0, 1'b0, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("rst setup", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst half pstrb", 32'(apbm_pstrb), 32'hC);
    nxt();
    neg(); chk_ctl("rst access", 1'b0, 1'b0, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_ctl("rst async", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst async pstrb", 32'(apbm_pstrb), 32'h0);
    check("rst async hrdata", ahbls_hrdata, 32'h0);
    neg();
    rst_n = 1'b1;
    nxt();
    addr_phase(32'h4000_0044, 1'b0, 3'd2, 4'b0001, 1'b0);
    apbm_pready = 1'b1;
    apbm_prdata = 32'h600D_CAFE;
    neg(); chk_ctl("post rst idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
    bus_idle();
    neg(); chk_ctl("post rst sample", 1'b0, 1'b0, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("post rst setup", 1'b0, 1'b0, 1'b1, 1'b0);
    check("post rst paddr", apbm_paddr, 32'h4000_0044);
    nxt();
    neg(); chk_ctl("post rst access", 1'b0, 1'b0, 1'b1, 1'b1); nxt();
    neg(); chk_ctl("post rst resp", 1'b1, 1'b0, 1'b0, 1'b0);
    check("post rst hrdata", ahbls_hrdata, 32'h600D_CAFE);
    nxt();

    // ---------------- Stalled slave: timeout or indefinite wait ----------------
    addr_phase(32'h4000_0050, 1'b0, 3'd2, 4'b0001, 1'b0);
    apbm_pready = 1'b0;
    apbm_prdata = 32'hFFFF_0000;
    neg(); chk_ctl("to idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
    bus_idle();
    neg(); chk_ctl("to sample", 1'b0, 1'b0, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("to setup", 1'b0, 1'b0, 1'b1, 1'b0); nxt();
`ifdef AHBL_TO_APB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      neg(); chk_ctl("to access", 1'b0, 1'b0, 1'b1, 1'b1); nxt();
    end
    apbm_pready = 1'b1;
    neg(); chk_ctl("to err1", 1'b0, 1'b1, 1'b0, 1'b0); nxt();
    neg(); chk_ctl("to err2", 1'b1, 1'b1, 1'b0, 1'b0);
    check("to hrdata kept", ahbls_hrdata, 32'h600D_CAFE);
    nxt();
    apbm_pready = 1'b0;
    neg(); chk_ctl("to back to idle", 1'b1, 1'b0, 1'b0, 1'b0); nxt();
`else
    repeat (100) nxt();
    neg(); chk_ctl("no-to still access", 1'b0, 1'b0, 1'b1, 1'b1);
    apbm_pready = 1'b1;
    nxt();
    neg(); chk_ctl("no-to resp", 1'b1, 1'b0, 1'b0, 1'b0);
    check("no-to hrdata", ahbls_hrdata, 32'hFFFF_0000);
    nxt();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_to_apb.md
Name: ahbl_to_apb

Overview:
- AHB-lite slave that converts single transfers into APB4 transfers. Intended as one downstream port of the busfabric 1:N splitter, where it serves the peripheral region (UART, timer, GPIO).
- Supports one outstanding transfer with no bursts. Exclusive accesses always fail.
- Adds fixed bridge latency plus the APB wait states.

Parameters:
- W_ADDR, 32, address width on both the AHB and APB sides.
- W_DATA, 32, data width. Only 32 is supported.
- TIMEOUT_CYCLES, 1024, APB ACCESS cycles allowed before a forced error. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ahbls_hready  in  1  bus-level HREADY. Address phase is accepted only when this is high.
- ahbls_hready_resp  out  1  data-phase ready to the splitter
- ahbls_hresp  out  1  error response
- ahbls_haddr  in  W_ADDR  address
- ahbls_hwrite  in  1  write
- ahbls_htrans  in  2  transfer type
- ahbls_hsize  in  3  size
- ahbls_hprot  in  4  protection
- ahbls_hwdata  in  W_DATA  write data, valid in the data phase
- ahbls_hrdata  out  W_DATA  read data
- ahbls_hexcl  in  1  exclusive request
- ahbls_hexokay  out  1  exclusive okay. Always 0.
- apbm_paddr  out  W_ADDR
- apbm_psel  out  1
- apbm_penable  out  1
- apbm_pwrite  out  1
- apbm_pwdata  out  W_DATA
- apbm_pstrb  out  4
- apbm_pprot  out  3
- apbm_prdata  in  W_DATA
- apbm_pready  in  1
- apbm_pslverr  in  1

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - state = IDLE
  - hready_resp = 1, hresp = 0, hrdata = 0
  - psel = 0, penable = 0, pwrite = 0
  - paddr, pwdata, pstrb, pprot = 0
  - Reset mid-transfer abandons the APB cycle immediately. psel and penable drop asynchronously.
- Accept condition: ahbls_hready && ahbls_htrans[1]. It is evaluated every cycle.
  - On accept, latch haddr, hwrite, hsize, haddr[1:0] and hprot, then go to SAMPLE.
  - Accept is only legal while hready_resp = 1 (IDLE, RESP, ERR2). It is never sampled in other states.
  - IDLE and BUSY htrans are ignored and return an OKAY zero-wait response.
- States and outputs:
  - IDLE: hready_resp = 1.
  - SAMPLE: hready_resp = 0. Latch hwdata into pwdata; for reads pwdata is a don't-care. Go to SETUP.
  - SETUP: psel = 1, penable = 0, paddr and pwrite driven from the latches. Go to ACCESS.
  - ACCESS: psel = 1, penable = 1, held until pready = 1.
    - pready with pslverr = 0: latch prdata into hrdata, go to RESP.
    - pready with pslverr = 1: go to ERR1.
  - RESP: hready_resp = 1, hresp = 0, psel = 0. If accept, go to SAMPLE; else go to IDLE.
  - ERR1: hready_resp = 0, hresp = 1.
  - ERR2: hready_resp = 1, hresp = 1. If accept, go to SAMPLE; else go to IDLE.
    - An accept in ERR2 is legal per AHB, since the master may already have issued the next address.
- Latency:
  - Zero-wait APB: the data phase is 4 cycles (hready_resp low for 3, high on the 4th).
  - Each APB wait state adds 1 cycle.
- pstrb is derived from the latched hsize and addr[1:0]:
  - byte: 1 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - hsize > 2: 4'b1111
  - pstrb = 0 on reads (APB4 rule).
- pprot = {~hprot[0], 1'b0, hprot[1]}: data/instr, secure, privileged.
- hrdata holds its last value outside RESP.
- hexokay is tied to 0. An exclusive write is still performed on APB; the master sees the exclusive fail.
- psel/penable/paddr/pwrite/pwdata/pstrb stay stable from SETUP through the final ACCESS cycle.

Optional Feature:
- Macro: AHBL_TO_APB_TIMEOUT_EN.
- Defined: a counter runs while in ACCESS and is cleared on leaving ACCESS.
  - After TIMEOUT_CYCLES ACCESS cycles without pready, psel and penable drop and the state goes to ERR1, giving the two-cycle AHB error.
  - prdata is not latched on timeout.
  - A late pready after the timeout is ignored.
  - Width: $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter. ACCESS waits indefinitely for pready.

Test Plan:
- Read, zero wait: read to 0x40000004, pready = 1 in the first ACCESS cycle, prdata = 0xDEADBEEF.
  - Expect psel high for 2 cycles and penable for 1 cycle.
  - Expect hready_resp low for 3 cycles, then high with hrdata = 0xDEADBEEF and hresp = 0.
- Byte write with waits: write hsize = 0 to 0x40000013 with hwdata = 0x5A000000, pready held low for 2 ACCESS cycles.
  - Expect pstrb = 4'b1000, pwdata = 0x5A000000 and pwrite = 1, all stable.
  - Expect hready_resp low for 5 cycles.
- Slave error: read with pslverr = 1 on pready.
  - Expect hresp = 1 with hready_resp = 0, then hresp = 1 with hready_resp = 1, then IDLE.
  - Expect hrdata unchanged from its previous value.
- Back-to-back with excl: write accepted in RESP of the prior read, with hexcl = 1.
  - Expect SAMPLE the next cycle, with no IDLE gap.
  - Expect hexokay = 0 throughout and the APB write performed.
- Reset mid-ACCESS: assert rst_n low during ACCESS.
  - Expect psel = 0, penable = 0 and hready_resp = 1 asynchronously.
  - Expect the next transfer after reset release to complete normally.
- Timeout (AHBL_TO_APB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): pready held 0.
  - Expect exactly 8 ACCESS cycles, then psel dropped and the two-cycle error response.
  - Without the macro, expect the bridge still in ACCESS after 100 cycles.
